// File: rtl/instr_fetch_ctrl_pkg.sv
// rtl/instr_fetch_ctrl_pkg.sv - shared fetch FSM encoding and buffer entry type
package instr_fetch_ctrl_pkg;

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_INSTR_WIDTH   = 32;

    typedef struct packed {
        logic [DEF_ADDRESS_WIDTH-1:0] pc;
        logic [DEF_INSTR_WIDTH-1:0]   instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_ctrl_fetch_buffer.sv
// rtl/instr_fetch_ctrl_fetch_buffer.sv - 2-entry fetch FIFO (module fetch_buffer)
module fetch_buffer
    import instr_fetch_ctrl_pkg::*;
#(
    parameter type entry_t = fetch_entry_t
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entry_t     push_data,
    output logic [1:0] count,
    output logic       head_valid,
    output entry_t     head
);

    entry_t slot0;
    entry_t slot1;

    // slot0 is always the head; a pop shifts slot1 down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) slot0 <= push_data;
                    else               slot1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_valid = (count != 2'd0);
    assign head       = slot0;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - ROM fetch controller; IFETCH_PERF_CNT_EN enables perf counters
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH = 32,
    parameter int                     INSTR_WIDTH   = 32,
    parameter int                     MEM_DEPTH     = 100,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                     CLK,
    input  logic                     RST,
    output logic [ADDRESS_WIDTH-1:0] InstrAddress,
    input  logic [INSTR_WIDTH-1:0]   InstrData,
    input  logic                     Redirect,
    input  logic [ADDRESS_WIDTH-1:0] RedirectTarget,
    output logic                     FetchValid,
    input  logic                     FetchReady,
    output logic [INSTR_WIDTH-1:0]   FetchInstr,
    output logic [ADDRESS_WIDTH-1:0] FetchPC,
    output logic                     Fault,
    output logic [ADDRESS_WIDTH-1:0] FaultPC,
    output logic [31:0]              PerfFetchCnt,
    output logic [31:0]              PerfStallCnt
);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [INSTR_WIDTH-1:0]   instr;
    } entry_t;

    localparam logic [ADDRESS_WIDTH-1:0] MEM_WORDS = ADDRESS_WIDTH'(MEM_DEPTH);

    logic [1:0]               state;
    logic [ADDRESS_WIDTH-1:0] fpc;
    logic [1:0]               count;
    entry_t                   head;
    entry_t                   push_data;
    logic                     pop;
    logic                     room;
    logic                     illegal;
    logic                     run_ok;
    logic                     push;
    logic                     fault_hit;
    logic                     flush;

    assign pop       = FetchValid && FetchReady;
    assign room      = (count != 2'd2) || pop;
    assign illegal   = (fpc[1:0] != 2'b00) || ((fpc >> 2) >= MEM_WORDS);
    assign run_ok    = (state == ST_RUN) && !Redirect;
    assign push      = run_ok && !illegal && room;
    // A fault is only taken once a slot would be free, so buffered work is never lost
    assign fault_hit = run_ok && illegal && room;
    assign flush     = Redirect && (state != ST_BOOT);
    assign push_data = '{pc: fpc, instr: InstrData};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_BOOT;
            fpc     <= RESET_PC;
            Fault   <= 1'b0;
            FaultPC <= '0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (Redirect) begin
                        fpc <= RedirectTarget;
                    end else if (fault_hit) begin
                        Fault   <= 1'b1;
                        FaultPC <= fpc;
                        state   <= ST_FAULT;
                    end else if (push) begin
                        fpc <= fpc + ADDRESS_WIDTH'(4);
                    end
                end
                ST_FAULT: begin
                    if (Redirect) begin
                        fpc   <= RedirectTarget;
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

    fetch_buffer #(
        .entry_t (entry_t)
    ) u_fetch_buffer (
        .clk        (CLK),
        .rst_n      (RST),
        .push       (push),
        .pop        (pop && !flush),
        .flush      (flush),
        .push_data  (push_data),
        .count      (count),
        .head_valid (FetchValid),
        .head       (head)
    );

    assign InstrAddress = fpc;
    assign FetchInstr   = head.instr;
    assign FetchPC      = head.pc;

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            PerfFetchCnt <= 32'd0;
            PerfStallCnt <= 32'd0;
        end else begin
            if (pop)                       PerfFetchCnt <= PerfFetchCnt + 32'd1;
            if (FetchValid && !FetchReady) PerfStallCnt <= PerfStallCnt + 32'd1;
        end
    end
`else
    assign PerfFetchCnt = 32'd0;
    assign PerfStallCnt = 32'd0;
`endif

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Fetch controller that sequences the instruction memory ROM. It owns the fetch PC, drives the ROM byte address each cycle, and captures the returned word into a 2-entry fetch buffer. It presents the buffered instructions to the decode stage over a valid/ready handshake. Branch/jump redirects from the datapath flush the buffer and restart fetch at the new target. Illegal fetch addresses raise a sticky fault.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 32, byte-address width
- `INSTR_WIDTH`, 32, instruction word width
- `MEM_DEPTH`, 100, ROM depth in words; legal fetch range is 0 .. 4*MEM_DEPTH-4
- `RESET_PC`, 0, fetch PC loaded on reset

Ports:
- `CLK`  in  1  sole clock, rising edge
- `RST`  in  1  asynchronous, active-low reset
- `InstrAddress`  out  ADDRESS_WIDTH  byte address to the ROM (current fetch PC)
- `InstrData`  in  INSTR_WIDTH  combinational ROM read data for `InstrAddress`
- `Redirect`  in  1  one-cycle pulse: discard buffered and in-flight fetches, restart at `RedirectTarget`
- `RedirectTarget`  in  ADDRESS_WIDTH  new fetch PC
- `FetchValid`  out  1  buffer head is valid
- `FetchReady`  in  1  decode accepts the head this cycle
- `FetchInstr`  out  INSTR_WIDTH  head instruction
- `FetchPC`  out  ADDRESS_WIDTH  byte address of the head instruction
- `Fault`  out  1  sticky illegal-fetch indication
- `FaultPC`  out  ADDRESS_WIDTH  PC that caused the fault

## Operation
State machine states: BOOT, RUN, FAULT.
- **BOOT:** entered on reset. Performs no fetch. Goes to RUN at the next edge.
- **RUN, per edge (priority order):**
  1. Redirect: flush the buffer (count := 0), set FPc := `RedirectTarget`, stay in RUN. A redirect wins over a simultaneous pop or capture.
  2. Illegal fetch: FPc is illegal if FPc[1:0] != 0 or FPc>>2 >= MEM_DEPTH. If the buffer has room, do not capture. Instead set `Fault` := 1, `FaultPC` := FPc, and go to FAULT.
  3. Normal fetch: when there is room (count < 2, or count == 2 with a pop this cycle), push {FPc, `InstrData`} and set FPc := FPc + 4. Addition wraps modulo 2^ADDRESS_WIDTH.
  4. Pop: when `FetchValid` && `FetchReady`, drop the head.
- **FAULT:**
  - No captures. Buffered entries still drain normally.
  - `Redirect` clears the buffer, loads FPc, and returns to RUN. `Fault` and `FaultPC` stay held until reset.
- `InstrAddress` = FPc in every state.
- The buffer is FIFO ordered. `FetchInstr`/`FetchPC` show the head; they hold their value while `FetchValid` && !`FetchReady`.

## Timing
Reset values:
- FPc = RESET_PC, state = BOOT, count = 0
- `FetchValid` = 0, `FetchInstr` = 0, `FetchPC` = 0
- `Fault` = 0, `FaultPC` = 0

Latency and throughput:
- After `RST` rises, edge 1 moves BOOT to RUN. Edge 2 captures the word at RESET_PC, so `FetchValid` = 1 after edge 2.
- Throughput is 1 instruction/cycle with `FetchReady` held high.
- With `FetchReady` low, the buffer fills in 2 cycles, then FPc freezes.
- Redirect sampled at edge N: `FetchValid` = 0 after edge N. The target instruction is valid after edge N+1 (one bubble).

Handshake and boundaries:
- `FetchValid` depends only on registered state. It never combinationally depends on `FetchReady`.
- Full + pop in the same cycle: push and pop both occur, count stays 2.
- Reset mid-operation: all state returns to reset values asynchronously and buffered instructions are lost.

## Configuration
- **`IFETCH_PERF_CNT_EN` defined:** adds 32-bit outputs `PerfFetchCnt` and `PerfStallCnt`.
  - `PerfFetchCnt` increments on each accepted pop.
  - `PerfStallCnt` increments each cycle with `FetchValid` && !`FetchReady`.
  - Both reset to 0, wrap at 2^32, and are unaffected by `Redirect`.
- **Not defined:** both ports still exist and are tied to 0. No counter logic is compiled.

## Structure
- **Shared package:** state encoding (BOOT=2'd0, RUN=2'd1, FAULT=2'd2) and the buffer entry typedef {pc, instr}. Both go in the shared processor definitions package.
- **Sub-module:** one, `fetch_buffer`, a 2-entry FIFO with push/pop/flush, count, and head outputs. The controller FSM and PC logic stay in the top module.

## Test plan
- **Reset boot:** ROM[0]=0x20080005, ROM[1]=0x20090003, `FetchReady`=1. Required: `FetchValid` rises after edge 2 with `FetchPC`=0x0, `FetchInstr`=0x20080005; the next cycle shows 0x4 / 0x20090003.
- **Back-pressure:** `FetchReady`=0 for 5 cycles. Required: count saturates at 2, `InstrAddress` freezes at 0x8, and the head holds 0x0. On release, 0x0, 0x4, 0x8 issue on consecutive cycles.
- **Redirect with simultaneous pop:** buffer holds 0x10 and 0x14; pulse `Redirect` to 0x40 while `FetchReady`=1. Required: next cycle `FetchValid`=0; the cycle after, `FetchPC`=0x40. Neither 0x14 nor 0x18 is ever shown.
- **Out-of-range fault:** MEM_DEPTH=4, run from 0. Required: 0x0–0xC are delivered, then `Fault`=1 with `FaultPC`=0x10, and no further captures. A later `Redirect` to 0x0 resumes fetch while `Fault` stays 1.
- **Misaligned redirect:** `Redirect` to 0x6. Required: `Fault`=1, `FaultPC`=0x6, `FetchValid` stays 0.
- **Perf counters** (with `IFETCH_PERF_CNT_EN`): 3 accepts and 2 stall cycles. Required: `PerfFetchCnt`=3, `PerfStallCnt`=2.
